// File: rtl/axi_pkg.sv
// Shared AXI encodings, FSM states and burst context for the memory slave.
package axi_pkg;

  localparam int unsigned LEN_W   = 4;
  localparam int unsigned BURST_W = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Burst attributes latched at the address handshake.
  typedef struct packed {
    logic [LEN_W-1:0]   len;
    logic [BURST_W-1:0] burst;
  } burst_cfg_t;

endpackage

// File: rtl/axi_burst_addr.sv
// Word-index stepper for FIXED / INCR / WRAP bursts (reserved type behaves as INCR).
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic [BURST_W-1:0] burst_i,
  output logic [IDX_W-1:0]   next_idx_c_o
);

  logic [LEN_W-1:0] len_mask_c;
  logic [IDX_W-1:0] wrap_mask_c;
  logic [IDX_W-1:0] inc_c;

  // Wrap mask covers the low $clog2(LEN+1) bits: smear LEN's top set bit downwards.
  always_comb begin
    len_mask_c   = len_i | (len_i >> 1) | (len_i >> 2) | (len_i >> 3);
    wrap_mask_c  = IDX_W'(len_mask_c);
    inc_c        = idx_i + IDX_W'(1);
    next_idx_c_o = inc_c;
    unique case (burst_i)
      BURST_FIXED: next_idx_c_o = idx_i;
      BURST_WRAP:  next_idx_c_o = (idx_i & ~wrap_mask_c) | (inc_c & wrap_mask_c);
      default:     next_idx_c_o = inc_c;
    endcase
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI3-style slave fronting a small word-addressed register memory.
module axi_mem_slave
  import axi_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SID_WIDTH  = 5,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [SID_WIDTH-1:0]  AWID,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [3:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic [1:0]            AWLOCK,
  input  logic [3:0]            AWCACHE,
  input  logic [2:0]            AWPROT,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [SID_WIDTH-1:0]  WID,
  input  logic [BUS_WIDTH-1:0]  WDATA,
  input  logic [3:0]            WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [SID_WIDTH-1:0]  BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [SID_WIDTH-1:0]  ARID,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [3:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic [1:0]            ARLOCK,
  input  logic [3:0]            ARCACHE,
  input  logic [2:0]            ARPROT,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [SID_WIDTH-1:0]  RID,
  output logic [BUS_WIDTH-1:0]  RDATA,
  output logic [3:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(DEPTH * 4);

  logic [31:0] mem_q [DEPTH];

  // Write path state
  w_state_e             w_state_q, w_state_d;
  logic [SID_WIDTH-1:0] wid_q, wid_d;
  burst_cfg_t           wcfg_q, wcfg_d;
  logic [IW-1:0]        widx_q, widx_d, wnext_c;
  logic [LEN_W-1:0]     wbeat_q, wbeat_d;
  logic                 wdec_q, wdec_d, wslv_q, wslv_d;
  logic [SID_WIDTH-1:0] bid_q, bid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic                 bvalid_q, bvalid_d;
  logic                 mem_we_c, beat_err_c;
  logic [31:0]          wdata_c;
  logic [IW-1:0]        aw_idx_c;
  logic                 aw_oor_c;

  // Read path state
  r_state_e             r_state_q, r_state_d;
  logic [SID_WIDTH-1:0] rid_q, rid_d;
  burst_cfg_t           rcfg_q, rcfg_d;
  logic [IW-1:0]        ridx_q, ridx_d, rnext_c, rstep_idx_c;
  burst_cfg_t           rstep_cfg_c;
  logic [LEN_W-1:0]     rbeat_q, rbeat_d;
  logic                 rdec_q, rdec_d;
  logic [1:0]           rresp_q, rresp_d;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                 rlast_q, rlast_d, rvalid_q, rvalid_d;
  logic [IW-1:0]        ar_idx_c;
  logic                 ar_oor_c;

  // Protection/cache/lock attributes are accepted but have no effect.
  logic unused_attr_c;
  assign unused_attr_c = ^{AWLOCK, AWCACHE, AWPROT, ARLOCK, ARCACHE, ARPROT};

  assign aw_idx_c = AWADDR[IW+1:2];
  assign aw_oor_c = (AWADDR >= MEM_BYTES);
  assign ar_idx_c = ARADDR[IW+1:2];
  assign ar_oor_c = (ARADDR >= MEM_BYTES);
  assign wdata_c  = 32'(WDATA);

  assign AWREADY = (w_state_q == W_IDLE);
  assign WREADY  = (w_state_q == W_DATA);
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = (r_state_q == R_IDLE);
  assign RVALID  = rvalid_q;
  assign RID     = rid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = {2'b00, rresp_q};
  assign RLAST   = rlast_q;

  // The read stepper sees the AR request while idle so beat 0's successor is ready at handshake.
  assign rstep_idx_c = (r_state_q == R_IDLE) ? ar_idx_c : ridx_q;
  assign rstep_cfg_c = (r_state_q == R_IDLE) ? burst_cfg_t'({ARLEN, ARBURST}) : rcfg_q;

  axi_burst_addr #(.IDX_W(IW)) u_w_step (
    .idx_i        (widx_q),
    .len_i        (wcfg_q.len),
    .burst_i      (wcfg_q.burst),
    .next_idx_c_o (wnext_c)
  );

  axi_burst_addr #(.IDX_W(IW)) u_r_step (
    .idx_i        (rstep_idx_c),
    .len_i        (rstep_cfg_c.len),
    .burst_i      (rstep_cfg_c.burst),
    .next_idx_c_o (rnext_c)
  );

  // Write FSM next state: AW latch, per-beat error tracking, response generation.
  always_comb begin
    w_state_d  = w_state_q;
    wid_d      = wid_q;
    wcfg_d     = wcfg_q;
    widx_d     = widx_q;
    wbeat_d    = wbeat_q;
    wdec_d     = wdec_q;
    wslv_d     = wslv_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    bvalid_d   = bvalid_q;
    mem_we_c   = 1'b0;
    beat_err_c = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (AWVALID) begin
          w_state_d = W_DATA;
          wid_d     = AWID;
          wcfg_d    = {AWLEN, AWBURST};
          widx_d    = aw_idx_c;
          wbeat_d   = '0;
          wdec_d    = aw_oor_c;
          wslv_d    = (AWSIZE != SIZE_WORD);
        end
      end
      W_DATA: begin
        if (WVALID) begin
          beat_err_c = (WID != wid_q) || (WLAST != (wbeat_q == wcfg_q.len));
          mem_we_c   = !wdec_q && !wslv_q && !beat_err_c;
          widx_d     = wnext_c;
          wbeat_d    = wbeat_q + LEN_W'(1);
          wslv_d     = wslv_q | beat_err_c;
          if (WLAST) begin
            w_state_d = W_RESP;
            bvalid_d  = 1'b1;
            bid_d     = wid_q;
            if (wdec_q)                   bresp_d = RESP_DECERR;
            else if (wslv_q | beat_err_c) bresp_d = RESP_SLVERR;
            else                          bresp_d = RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        if (BREADY) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write path registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      w_state_q <= W_IDLE;
      wid_q     <= '0;
      wcfg_q    <= '0;
      widx_q    <= '0;
      wbeat_q   <= '0;
      wdec_q    <= 1'b0;
      wslv_q    <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      wid_q     <= wid_d;
      wcfg_q    <= wcfg_d;
      widx_q    <= widx_d;
      wbeat_q   <= wbeat_d;
      wdec_q    <= wdec_d;
      wslv_q    <= wslv_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // Byte-lane masked memory write.
  always_ff @(posedge clk) begin
    if (clr) begin
      mem_q <= '{default: '0};
    end else if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (WSTRB[b]) mem_q[widx_q][8*b +: 8] <= wdata_c[8*b +: 8];
      end
    end
  end

  // Read FSM next state: each accepted beat loads the following word.
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    rcfg_d    = rcfg_q;
    ridx_d    = ridx_q;
    rbeat_d   = rbeat_q;
    rdec_d    = rdec_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    rlast_d   = rlast_q;
    rvalid_d  = rvalid_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ARVALID) begin
          r_state_d = R_DATA;
          rid_d     = ARID;
          rcfg_d    = {ARLEN, ARBURST};
          ridx_d    = rnext_c;
          rbeat_d   = '0;
          rdec_d    = ar_oor_c;
          if (ar_oor_c)                rresp_d = RESP_DECERR;
          else if (ARSIZE != SIZE_WORD) rresp_d = RESP_SLVERR;
          else                          rresp_d = RESP_OKAY;
          rdata_d   = ar_oor_c ? '0 : BUS_WIDTH'(mem_q[ar_idx_c]);
          rlast_d   = (ARLEN == '0);
          rvalid_d  = 1'b1;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          if (rlast_q) begin
            r_state_d = R_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
          end else begin
            rbeat_d = rbeat_q + LEN_W'(1);
            rlast_d = ((rbeat_q + LEN_W'(1)) == rcfg_q.len);
            rdata_d = rdec_q ? '0 : BUS_WIDTH'(mem_q[ridx_q]);
            ridx_d  = rnext_c;
          end
        end
      end
    endcase
  end

  // Read path registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      rcfg_q    <= '0;
      ridx_q    <= '0;
      rbeat_q   <= '0;
      rdec_q    <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      rlast_q   <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      rcfg_q    <= rcfg_d;
      ridx_q    <= ridx_d;
      rbeat_q   <= rbeat_d;
      rdec_q    <= rdec_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      rlast_q   <= rlast_d;
      rvalid_q  <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed, table-driven bench for axi_mem_slave (DEPTH=16, 32-bit data).
module tb_axi_mem_slave;

  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        clr;
  logic [4:0]  AWID, WID, BID, ARID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  AWLEN, ARLEN, AWCACHE, ARCACHE, WSTRB, RRESP;
  logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
  logic [1:0]  AWBURST, ARBURST, AWLOCK, ARLOCK, BRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  axi_mem_slave dut (
    .clk(clk), .clr(clr),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              wr;
    logic [31:0]     addr;
    logic [3:0]      len;
    logic [1:0]      burst;
    logic [2:0]      size;
    logic [4:0]      id;
    logic [3:0]      strb;
    logic [31:0]     d0;
    int              last_at;
    bit              badid;
    logic [1:0]      eresp;
    logic [3:0][31:0] e;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] rd_data [16];
  logic [3:0]  rd_resp [16];
  logic        rd_last [16];
  logic [4:0]  rd_id   [16];
  int          rd_gap;
  vec_t        vec [21];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    end
  endtask

  task automatic tmo(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no handshake within %0d cycles", name, TMO);
  endtask

  function automatic vec_t mkw(input logic [31:0] a, input logic [3:0] l, input logic [1:0] bu,
                               input logic [2:0] s, input logic [4:0] id, input logic [3:0] st,
                               input logic [31:0] d, input int la, input bit bad,
                               input logic [1:0] er);
    vec_t v;
    v.wr = 1'b1; v.addr = a; v.len = l; v.burst = bu; v.size = s; v.id = id; v.strb = st;
    v.d0 = d; v.last_at = la; v.badid = bad; v.eresp = er; v.e = '0;
    return v;
  endfunction

  function automatic vec_t mkr(input logic [31:0] a, input logic [3:0] l, input logic [1:0] bu,
                               input logic [2:0] s, input logic [4:0] id, input logic [1:0] er,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
    vec_t v;
    v.wr = 1'b0; v.addr = a; v.len = l; v.burst = bu; v.size = s; v.id = id; v.strb = 4'h0;
    v.d0 = '0; v.last_at = 0; v.badid = 1'b0; v.eresp = er; v.e = {e3, e2, e1, e0};
    return v;
  endfunction

  task automatic send_aw_w(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [4:0] id, input logic [3:0] strb,
                           input logic [31:0] d0, input int last_at, input bit badid);
    int n;
    AWADDR = addr; AWLEN = len; AWBURST = burst; AWSIZE = size; AWID = id; AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < TMO) begin @(posedge clk); #1; n++; end
    if (n >= TMO) tmo("aw_ready");
    @(posedge clk); #1;
    AWVALID = 1'b0;
    for (int b = 0; b <= last_at; b++) begin
      WVALID = 1'b1;
      WID    = badid ? (id ^ 5'h01) : id;
      WDATA  = d0 + 32'(b);
      WSTRB  = strb;
      WLAST  = (b == last_at);
      n = 0;
      while (!WREADY && n < TMO) begin @(posedge clk); #1; n++; end
      if (n >= TMO) tmo("w_ready");
      @(posedge clk); #1;
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
  endtask

  task automatic get_b(output logic [1:0] resp, output logic [4:0] bid);
    int n;
    BREADY = 1'b1;
    n = 0;
    while (!BVALID && n < TMO) begin @(posedge clk); #1; n++; end
    if (n >= TMO) tmo("b_valid");
    resp = BRESP;
    bid  = BID;
    @(posedge clk); #1;
    BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst,
                         input logic [2:0] size, input logic [4:0] id);
    int n;
    ARADDR = addr; ARLEN = len; ARBURST = burst; ARSIZE = size; ARID = id; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < TMO) begin @(posedge clk); #1; n++; end
    if (n >= TMO) tmo("ar_ready");
    @(posedge clk); #1;
    ARVALID = 1'b0;
    RREADY  = 1'b1;
    rd_gap  = 0;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!RVALID && n < TMO) begin @(posedge clk); #1; n++; end
      if (n >= TMO) tmo("r_valid");
      rd_gap     += n;
      rd_data[b] = RDATA;
      rd_resp[b] = RRESP;
      rd_last[b] = RLAST;
      rd_id[b]   = RID;
      @(posedge clk); #1;
    end
    RREADY = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_awready"}, 32'(AWREADY), 32'd1);
    chk({tag, "_arready"}, 32'(ARREADY), 32'd1);
    chk({tag, "_bvalid"},  32'(BVALID),  32'd0);
    chk({tag, "_rvalid"},  32'(RVALID),  32'd0);
    chk({tag, "_rlast"},   32'(RLAST),   32'd0);
    chk({tag, "_bid"},     32'(BID),     32'd0);
    chk({tag, "_rid"},     32'(RID),     32'd0);
    chk({tag, "_bresp"},   32'(BRESP),   32'd0);
    chk({tag, "_rresp"},   32'(RRESP),   32'd0);
    chk({tag, "_rdata"},   RDATA,        32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [4:0]  bid;
    logic [31:0] tex [4];
    vec_t        v;
    int          n, beats, cyc;
    bit          rr;

    // Writes/reads in order; memory contents build up from all-zero reset.
    vec[0]  = mkw(32'h08,  4'd0, 2'b01, 3'b010, 5'd3, 4'hF, 32'hDEADBEEF, 0, 1'b0, 2'b00);
    vec[1]  = mkr(32'h08,  4'd0, 2'b01, 3'b010, 5'd3, 2'b00, 32'hDEADBEEF, 0, 0, 0);
    vec[2]  = mkw(32'h38,  4'd3, 2'b01, 3'b010, 5'd1, 4'hF, 32'hA0000000, 3, 1'b0, 2'b00);
    vec[3]  = mkr(32'h38,  4'd3, 2'b01, 3'b010, 5'd2, 2'b00,
                  32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003);
    vec[4]  = mkw(32'h34,  4'd0, 2'b01, 3'b010, 5'd1, 4'hF, 32'h13131313, 0, 1'b0, 2'b00);
    vec[5]  = mkw(32'h30,  4'd0, 2'b01, 3'b010, 5'd1, 4'hF, 32'h0C0C0C0C, 0, 1'b0, 2'b00);
    vec[6]  = mkr(32'h34,  4'd3, 2'b10, 3'b010, 5'd4, 2'b00,
                  32'h13131313, 32'hA0000000, 32'hA0000001, 32'h0C0C0C0C);
    vec[7]  = mkw(32'h10,  4'd0, 2'b01, 3'b010, 5'd6, 4'hF, 32'hFFFFFFFF, 0, 1'b0, 2'b00);
    vec[8]  = mkw(32'h10,  4'd0, 2'b01, 3'b010, 5'd6, 4'h5, 32'h12345678, 0, 1'b0, 2'b00);
    vec[9]  = mkr(32'h10,  4'd0, 2'b01, 3'b010, 5'd7, 2'b00, 32'hFF34FF78, 0, 0, 0);
    vec[10] = mkw(32'h100, 4'd0, 2'b01, 3'b010, 5'd8, 4'hF, 32'h55555555, 0, 1'b0, 2'b11);
    vec[11] = mkr(32'h100, 4'd1, 2'b01, 3'b010, 5'd9, 2'b11, 32'h0, 32'h0, 0, 0);
    vec[12] = mkr(32'h00,  4'd0, 2'b01, 3'b001, 5'd9, 2'b10, 32'hA0000002, 0, 0, 0);
    vec[13] = mkw(32'h20,  4'd1, 2'b00, 3'b010, 5'd2, 4'hF, 32'h11110000, 1, 1'b0, 2'b00);
    vec[14] = mkr(32'h20,  4'd1, 2'b00, 3'b010, 5'd2, 2'b00, 32'h11110001, 32'h11110001, 0, 0);
    vec[15] = mkw(32'h24,  4'd0, 2'b01, 3'b001, 5'd5, 4'hF, 32'h77777777, 0, 1'b0, 2'b10);
    vec[16] = mkr(32'h24,  4'd0, 2'b01, 3'b010, 5'd5, 2'b00, 32'h0, 0, 0, 0);
    vec[17] = mkw(32'h28,  4'd0, 2'b01, 3'b010, 5'd4, 4'hF, 32'h66666666, 0, 1'b1, 2'b10);
    vec[18] = mkr(32'h28,  4'd0, 2'b01, 3'b010, 5'd4, 2'b00, 32'h0, 0, 0, 0);
    vec[19] = mkw(32'h2C,  4'd3, 2'b01, 3'b010, 5'd3, 4'hF, 32'hC0000000, 1, 1'b0, 2'b10);
    vec[20] = mkr(32'h2C,  4'd1, 2'b01, 3'b010, 5'd3, 2'b00, 32'hC0000000, 32'h0C0C0C0C, 0, 0);

    clr = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    AWLOCK = 2'b01; AWCACHE = 4'h3; AWPROT = 3'b010;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    ARLOCK = 2'b01; ARCACHE = 4'h3; ARPROT = 3'b010;
    WID = '0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
    BREADY = 1'b0; RREADY = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    chk_idle("reset");

    for (int i = 0; i < 21; i++) begin
      v = vec[i];
      if (v.wr) begin
        send_aw_w(v.addr, v.len, v.burst, v.size, v.id, v.strb, v.d0, v.last_at, v.badid);
        get_b(resp, bid);
        chk($sformatf("v%0d_bresp", i), 32'(resp), 32'(v.eresp));
        chk($sformatf("v%0d_bid", i), 32'(bid), 32'(v.id));
      end else begin
        do_read(v.addr, v.len, v.burst, v.size, v.id);
        for (int b = 0; b <= int'(v.len); b++) begin
          chk($sformatf("v%0d_b%0d_rdata", i, b), rd_data[b], v.e[b]);
          chk($sformatf("v%0d_b%0d_rresp", i, b), 32'(rd_resp[b]), 32'({2'b00, v.eresp}));
          chk($sformatf("v%0d_b%0d_rlast", i, b), 32'(rd_last[b]), 32'(b == int'(v.len)));
          chk($sformatf("v%0d_b%0d_rid", i, b), 32'(rd_id[b]), 32'(v.id));
        end
        chk($sformatf("v%0d_rgap", i), 32'(rd_gap), 32'd0);
        chk($sformatf("v%0d_rvalid_end", i), 32'(RVALID), 32'd0);
      end
    end

    // Response back-pressure: BVALID/BID/BRESP hold, no new AW accepted.
    send_aw_w(32'h1C, 4'd0, 2'b01, 3'b010, 5'd9, 4'hF, 32'hABCD0123, 0, 1'b0);
    n = 0;
    while (!BVALID && n < TMO) begin @(posedge clk); #1; n++; end
    if (n >= TMO) tmo("stall_bvalid");
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_bvalid", c), 32'(BVALID), 32'd1);
      chk($sformatf("stall%0d_bid", c), 32'(BID), 32'd9);
      chk($sformatf("stall%0d_bresp", c), 32'(BRESP), 32'd0);
      chk($sformatf("stall%0d_awready", c), 32'(AWREADY), 32'd0);
    end
    BREADY = 1'b1;
    @(posedge clk); #1;
    BREADY = 1'b0;
    chk("stall_bvalid_drop", 32'(BVALID), 32'd0);
    chk("stall_awready_back", 32'(AWREADY), 32'd1);
    do_read(32'h1C, 4'd0, 2'b01, 3'b010, 5'd9);
    chk("stall_readback", rd_data[0], 32'hABCD0123);

    // RREADY toggling across an INCR4 read of words 14,15,0,1.
    tex[0] = 32'hA0000000; tex[1] = 32'hA0000001; tex[2] = 32'hA0000002; tex[3] = 32'hA0000003;
    ARADDR = 32'h38; ARLEN = 4'd3; ARBURST = 2'b01; ARSIZE = 3'b010; ARID = 5'h0A; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < TMO) begin @(posedge clk); #1; n++; end
    if (n >= TMO) tmo("tog_arready");
    @(posedge clk); #1;
    ARVALID = 1'b0;
    beats = 0;
    cyc   = 0;
    while (beats < 4 && cyc < 40) begin
      rr     = (cyc % 3) != 0;
      RREADY = rr;
      if (RVALID) begin
        chk($sformatf("tog_c%0d_rdata", cyc), RDATA, tex[beats]);
        chk($sformatf("tog_c%0d_rlast", cyc), 32'(RLAST), 32'(beats == 3));
        chk($sformatf("tog_c%0d_rid", cyc), 32'(RID), 32'h0A);
        if (rr) beats++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    RREADY = 1'b0;
    chk("tog_beats", 32'(beats), 32'd4);
    chk("tog_rvalid_end", 32'(RVALID), 32'd0);

    // Reset during the third beat of an INCR4 write.
    AWADDR = 32'h0; AWLEN = 4'd3; AWBURST = 2'b01; AWSIZE = 3'b010; AWID = 5'd1; AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < TMO) begin @(posedge clk); #1; n++; end
    if (n >= TMO) tmo("clr_awready");
    @(posedge clk); #1;
    AWVALID = 1'b0;
    for (int b = 0; b < 2; b++) begin
      WVALID = 1'b1; WID = 5'd1; WDATA = 32'hEEEE0000 + 32'(b); WSTRB = 4'hF; WLAST = 1'b0;
      n = 0;
      while (!WREADY && n < TMO) begin @(posedge clk); #1; n++; end
      if (n >= TMO) tmo("clr_wready");
      @(posedge clk); #1;
    end
    WDATA = 32'hEEEE0002;
    clr   = 1'b1;
    @(posedge clk); #1;
    clr    = 1'b0;
    WVALID = 1'b0;
    chk_idle("clr_mid");
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("clr_nob%0d", c), 32'(BVALID), 32'd0);
    end
    do_read(32'h0, 4'd15, 2'b01, 3'b010, 5'd0);
    for (int b = 0; b < 16; b++) begin
      chk($sformatf("clr_mem%0d", b), rd_data[b], 32'h0);
      chk($sformatf("clr_rresp%0d", b), 32'(rd_resp[b]), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32: data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: address width in bits.
REQ-003 SHALL have parameter SID_WIDTH, default 5: slave-side ID width (ID_WIDTH+$clog2(M)).
REQ-004 SHALL have parameter DEPTH, default 16: number of 32-bit memory words; power of two; 2..256.
REQ-005 SHALL have port clk, in, 1: single clock; all logic on the rising edge.
REQ-006 SHALL have port clr, in, 1: reset, synchronous, active-high.
REQ-007 SHALL have ports AWID in SID_WIDTH, AWADDR in ADDR_WIDTH, AWLEN in 4, AWSIZE in 3 and AWBURST in 2: write address and burst attributes.
REQ-008 SHALL have ports AWLOCK in 2, AWCACHE in 4 and AWPROT in 3: accepted and ignored.
REQ-009 SHALL have ports AWVALID in 1 and AWREADY out 1: write address handshake.
REQ-010 SHALL have ports WID in SID_WIDTH, WDATA in BUS_WIDTH, WSTRB in 4, WLAST in 1, WVALID in 1 and WREADY out 1: write data channel.
REQ-011 SHALL have ports BID out SID_WIDTH, BRESP out 2, BVALID out 1 and BREADY in 1: write response channel.
REQ-012 SHALL have ports ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE and ARPROT in, with widths as the matching AW ports: read address and attributes.
REQ-013 SHALL have ports ARVALID in 1 and ARREADY out 1: read address handshake.
REQ-014 SHALL have ports RID out SID_WIDTH, RDATA out BUS_WIDTH, RRESP out 4, RLAST out 1, RVALID out 1 and RREADY in 1: read data channel; RRESP[3:2] always 0.

Function
REQ-015 Write FSM SHALL have states W_IDLE -> W_DATA -> W_RESP -> W_IDLE; AWREADY=1 only in W_IDLE; WREADY=1 only in W_DATA; BVALID=1 only in W_RESP.
REQ-016 On an AW handshake the block SHALL latch ID, LEN, SIZE, BURST and the word index ADDR[$clog2(DEPTH)+1:2], and clear the beat counter and error flags.
REQ-017 Each W handshake in W_DATA SHALL write WDATA byte lanes enabled by WSTRB into the current word, unless an error is flagged for that burst, then advance the index.
REQ-018 Index advance SHALL be: FIXED (00) hold; INCR (01) +1 modulo DEPTH; WRAP (10) increment only the low $clog2(LEN+1) bits; reserved burst type 11 treated as INCR.
REQ-019 Write error flags SHALL be: DECERR (11) if AWADDR >= DEPTH*4 (no writes); SLVERR (10) if AWSIZE != 010, WID != latched ID, or WLAST disagrees with beat counter == LEN (writes suppressed from the offending beat on); otherwise OKAY (00); DECERR overrides SLVERR.
REQ-020 W_DATA SHALL exit to W_RESP on the handshake carrying WLAST=1, regardless of the beat count.
REQ-021 BID and BRESP SHALL hold stable while BVALID=1 and BREADY=0; on BVALID&BREADY the FSM SHALL return to W_IDLE, with AWREADY=1 on the next cycle.
REQ-022 Read FSM SHALL have states R_IDLE and R_DATA; ARREADY=1 only in R_IDLE; RVALID=1 only in R_DATA.
REQ-023 The first R beat SHALL be valid on the cycle after the AR handshake; each later beat SHALL follow RVALID&RREADY with no bubble; RLAST=1 on beat LEN; RID = latched ARID.
REQ-024 RDATA, RRESP, RLAST and RID SHALL hold stable while RVALID=1 and RREADY=0.
REQ-025 Read errors SHALL be: out-of-range address gives RRESP=0011 with RDATA=0 on all beats; ARSIZE != 010 gives RRESP=0010 with data still returned.
REQ-026 Read and write FSMs SHALL run concurrently; a read of a word written in the same cycle SHALL return the old value.
REQ-027 Beat counter SHALL be 4 bits; index arithmetic SHALL be $clog2(DEPTH) bits with natural wrap.

Reset
REQ-028 While clr=1 at a clock edge, both FSMs SHALL go to idle, all memory words to 0, and BVALID, RVALID, RLAST, BID, RID, BRESP, RRESP and RDATA to 0; AWREADY=ARREADY=1 on the first cycle after reset.
REQ-029 Reset mid-burst SHALL abandon the burst with no response issued.

Structure
REQ-030 Response codes (OKAY, SLVERR, DECERR), burst encodings and FSM state encodings SHALL reside in shared package axi_pkg.
REQ-031 The burst address stepper (REQ-018) SHALL be sub-module axi_burst_addr, instantiated once for the write path and once for the read path.

Verification
REQ-032 Single write: AWADDR=0x8, LEN=0, WDATA=0xDEADBEEF, WSTRB=1111 -> BRESP=00; read at 0x8 -> RDATA=0xDEADBEEF, RLAST=1.
REQ-033 INCR4 write at 0x38 (DEPTH=16) -> words 14, 15, 0, 1 written; WRAP4 read at 0x34 -> words 13, 14, 15, 12.
REQ-034 WSTRB=0101 over 0xFFFFFFFF, WDATA=0x12345678 -> read returns 0xFF34FF78.
REQ-035 BREADY low for 5 cycles -> BVALID and BID stable, AWREADY=0; RREADY toggling -> no beat lost or duplicated.
REQ-036 AWADDR=0x100 -> BRESP=11, memory unchanged; WID mismatch -> BRESP=10; ARADDR=0x100, LEN=1 -> two beats, RRESP=0011, RDATA=0.
REQ-037 clr asserted during beat 2 of an INCR4 write -> FSMs idle, memory all 0, no BVALID.
